// File: rtl/alu_pkg.sv
// Shared definitions for the LEGv8 ALU opcode decoder: ALU mux select codes,
// the decoded control word, and the opcode encodings it recognises.
package alu_pkg;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  typedef struct packed {
    logic [2:0] cntrl;
    logic       set_flags;
    logic       use_imm;
    logic       illegal;
  } dec_word_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // Wildcard encodings are stored as their fixed leading bits only.
  localparam logic [9:0] OP_ADDI_PFX = 10'b1001000100;
  localparam logic [9:0] OP_SUBI_PFX = 10'b1101000100;
  localparam logic [7:0] OP_CBZ_PFX  = 8'b10110100;
  localparam logic [5:0] OP_B_PFX    = 6'b000101;

  function automatic dec_word_t mk_word(input logic [2:0] c, input logic sf,
                                        input logic imm, input logic ill);
    dec_word_t w;
    w.cntrl     = c;
    w.set_flags = sf;
    w.use_imm   = imm;
    w.illegal   = ill;
    return w;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer: registered main output plus one spill
// entry, so in_ready depends only on local state and never on out_ready.
module skid_buf #(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              vld_p1;
  logic              spill_vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [DATA_W-1:0] spill_data_p1;
  logic              accept;
  logic              main_free;

  assign in_ready  = !spill_vld_p1;
  assign accept    = in_valid && in_ready;
  assign main_free = !vld_p1 || out_ready;

  // Stage p1: main register and spill entry
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      spill_vld_p1 <= 1'b0;
    end else if (main_free) begin
      if (spill_vld_p1) begin
        vld_p1       <= 1'b1;
        spill_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= accept;
      end
    end else if (accept) begin
      spill_vld_p1 <= 1'b1;
    end
  end

  // The main payload is cleared on reset so the outputs read as a PASS_B no-op.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
    end else if (main_free) begin
      if (spill_vld_p1) begin
        data_p1 <= spill_data_p1;
      end else if (accept) begin
        data_p1 <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!main_free && accept) begin
      spill_data_p1 <= in_data;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;

endmodule

// File: rtl/alu_op_decoder.sv
// Streaming LEGv8 opcode -> ALU control decoder with one-cycle registered
// latency, skid-buffered handshake and a saturating illegal-opcode counter.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       alu_cntrl,
  output logic             set_flags,
  output logic             use_imm,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int WORD_W = $bits(dec_word_t);

  dec_word_t         dec_p0;
  dec_word_t         word_p1;
  logic [WORD_W-1:0] dec_bits_p0;
  logic [WORD_W-1:0] word_bits_p1;
  logic [CNT_W-1:0]  cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: decode, exact encodings take priority over wildcard prefixes
  always_comb begin
    dec_p0 = mk_word(ALU_PASS_B, 1'b0, 1'b0, 1'b1);
    case (opcode)
      OP_ADD:  dec_p0 = mk_word(ALU_ADD, 1'b0, 1'b0, 1'b0);
      OP_ADDS: dec_p0 = mk_word(ALU_ADD, 1'b1, 1'b0, 1'b0);
      OP_SUB:  dec_p0 = mk_word(ALU_SUB, 1'b0, 1'b0, 1'b0);
      OP_SUBS: dec_p0 = mk_word(ALU_SUB, 1'b1, 1'b0, 1'b0);
      OP_AND:  dec_p0 = mk_word(ALU_AND, 1'b0, 1'b0, 1'b0);
      OP_ORR:  dec_p0 = mk_word(ALU_OR,  1'b0, 1'b0, 1'b0);
      OP_EOR:  dec_p0 = mk_word(ALU_XOR, 1'b0, 1'b0, 1'b0);
      OP_LDUR: dec_p0 = mk_word(ALU_ADD, 1'b0, 1'b1, 1'b0);
      OP_STUR: dec_p0 = mk_word(ALU_ADD, 1'b0, 1'b1, 1'b0);
      default: begin
        if (opcode[10:1] == OP_ADDI_PFX) begin
          dec_p0 = mk_word(ALU_ADD, 1'b0, 1'b1, 1'b0);
        end else if (opcode[10:1] == OP_SUBI_PFX) begin
          dec_p0 = mk_word(ALU_SUB, 1'b0, 1'b1, 1'b0);
        end else if (opcode[10:3] == OP_CBZ_PFX) begin
          dec_p0 = mk_word(ALU_PASS_B, 1'b0, 1'b0, 1'b0);
        end else if (opcode[10:5] == OP_B_PFX) begin
          dec_p0 = mk_word(ALU_PASS_B, 1'b0, 1'b0, 1'b0);
        end
      end
    endcase
  end

  assign dec_bits_p0 = dec_p0;

  skid_buf #(
    .DATA_W (WORD_W)
  ) u_skid (
    .clk       (clk),
    .rst       (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_bits_p0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (word_bits_p1)
  );

  // Stage p1: counted at acceptance so stalled illegal words are not missed
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p1 <= '0;
    end else if (in_valid && in_ready && dec_p0.illegal) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign word_p1     = dec_word_t'(word_bits_p1);
  assign alu_cntrl   = word_p1.cntrl;
  assign set_flags   = word_p1.set_flags;
  assign use_imm     = word_p1.use_imm;
  assign illegal     = word_p1.illegal;
  assign illegal_cnt = cnt_p1;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: directed literal checks plus a randomized stream
// scored against a table-driven decode model and an occupancy queue.
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [10:0] opcode = '0;

  logic        in_ready, out_valid, set_flags, use_imm, illegal;
  logic [2:0]  alu_cntrl;
  logic [7:0]  illegal_cnt;

  logic        b_in_ready, b_out_valid, b_set_flags, b_use_imm, b_illegal;
  logic [2:0]  b_alu_cntrl;
  logic [1:0]  b_illegal_cnt;

  alu_op_decoder #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .alu_cntrl(alu_cntrl), .set_flags(set_flags), .use_imm(use_imm),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  alu_op_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .opcode(opcode), .out_valid(b_out_valid), .out_ready(out_ready),
    .alu_cntrl(b_alu_cntrl), .set_flags(b_set_flags), .use_imm(b_use_imm),
    .illegal(b_illegal), .illegal_cnt(b_illegal_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decode table: {mask, value, {cntrl, set_flags, use_imm}}, exact entries first
  logic [10:0] tmask [13] = '{11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF,
                              11'h7FF, 11'h7FF, 11'h7FF, 11'b11111111110,
                              11'b11111111110, 11'b11111111000, 11'b11111100000};
  logic [10:0] tval  [13] = '{11'b10001011000, 11'b10101011000, 11'b11001011000,
                              11'b11101011000, 11'b10001010000, 11'b10101010000,
                              11'b11001010000, 11'b11111000010, 11'b11111000000,
                              11'b10010001000, 11'b11010001000, 11'b10110100000,
                              11'b00010100000};
  logic [4:0]  tres  [13] = '{5'b010_0_0, 5'b010_1_0, 5'b011_0_0, 5'b011_1_0,
                              5'b100_0_0, 5'b101_0_0, 5'b110_0_0, 5'b010_0_1,
                              5'b010_0_1, 5'b010_0_1, 5'b011_0_1, 5'b000_0_0,
                              5'b000_0_0};

  function automatic logic [5:0] ref_decode(input logic [10:0] op);
    for (int i = 0; i < 13; i++)
      if ((op & tmask[i]) == tval[i]) return {tres[i], 1'b0};
    return 6'b000_0_0_1;
  endfunction

  // Reference model: words held by the decoder, oldest first (at most two)
  logic [5:0] q[$];
  int         cnt8 = 0;
  int         cnt2 = 0;
  bit         started = 0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      cnt8 = 0;
      cnt2 = 0;
      started = 1;
    end else if (started) begin
      bit acc, emt;
      logic [5:0] w;
      acc = in_valid && (q.size() < 2);
      emt = (q.size() > 0) && out_ready;
      if (emt) void'(q.pop_front());
      if (acc) begin
        w = ref_decode(opcode);
        q.push_back(w);
        if (w[0]) begin
          if (cnt8 < 255) cnt8++;
          if (cnt2 < 3) cnt2++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("b_out_valid", 32'(b_out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("payload", 32'({alu_cntrl, set_flags, use_imm, illegal}), 32'(q[0]));
        check("b_payload", 32'({b_alu_cntrl, b_set_flags, b_use_imm, b_illegal}), 32'(q[0]));
      end
      check("no_001_111", 32'(alu_cntrl == 3'b001 || alu_cntrl == 3'b111), 32'(0));
      check("illegal_cnt", 32'(illegal_cnt), 32'(cnt8));
      check("illegal_cnt_w2", 32'(b_illegal_cnt), 32'(cnt2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string name, input logic [2:0] c,
                             input logic sf, input logic imm, input logic ill);
    check({name, "_valid"}, 32'(out_valid), 32'(1));
    check({name, "_word"}, 32'({alu_cntrl, set_flags, use_imm, illegal}),
          32'({c, sf, imm, ill}));
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_word", 32'({alu_cntrl, set_flags, use_imm, illegal}), 32'(0));
    check("rst_cnt", 32'(illegal_cnt), 32'(0));
    reset = 1'b0;
    step();

    // Back-to-back stream with out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    opcode = 11'b10001011000; step(); expect_word("ADD",  3'b010, 0, 0, 0);
    opcode = 11'b11101011000; step(); expect_word("SUBS", 3'b011, 1, 0, 0);
    opcode = 11'b10101010000; step(); expect_word("ORR",  3'b101, 0, 0, 0);
    opcode = 11'b11001010000; step(); expect_word("EOR",  3'b110, 0, 0, 0);
    opcode = 11'b10010001001; step(); expect_word("ADDI", 3'b010, 0, 1, 0);
    in_valid = 1'b0; step();
    check("stream_drained", 32'(out_valid), 32'(0));

    // Backpressure: AND held in main, ORR into spill
    out_ready = 1'b0;
    in_valid  = 1'b1;
    opcode = 11'b10001010000; step(); expect_word("AND_held", 3'b100, 0, 0, 0);
    check("ready_after_1", 32'(in_ready), 32'(1));
    opcode = 11'b10101010000; step(); expect_word("AND_held2", 3'b100, 0, 0, 0);
    check("ready_after_2", 32'(in_ready), 32'(0));
    in_valid = 1'b0; step(); expect_word("AND_held3", 3'b100, 0, 0, 0);
    out_ready = 1'b1; step(); expect_word("ORR_after", 3'b101, 0, 0, 0);
    check("ready_restored", 32'(in_ready), 32'(1));
    step();
    check("bp_drained", 32'(out_valid), 32'(0));

    // Illegal opcodes and counter saturation
    in_valid = 1'b1;
    opcode = 11'b00000000000;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_word("ILL0", 3'b000, 0, 0, 1);
    end
    in_valid = 1'b0; step();
    check("cnt_3", 32'(illegal_cnt), 32'(3));
    check("cnt_w2_3", 32'(b_illegal_cnt), 32'(3));
    in_valid = 1'b1;
    opcode = 11'h7FF;
    repeat (2) step();
    in_valid = 1'b0; step();
    check("cnt_5", 32'(illegal_cnt), 32'(5));
    check("cnt_w2_sat", 32'(b_illegal_cnt), 32'(3));

    // Reset with spill full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    opcode = 11'b11001011000; step();
    opcode = 11'b10001010000; step();
    in_valid = 1'b0;
    check("full_in_ready", 32'(in_ready), 32'(0));
    check("full_out_valid", 32'(out_valid), 32'(1));
    reset = 1'b1; step();
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_cnt", 32'(illegal_cnt), 32'(0));
    check("mid_rst_cnt_w2", 32'(b_illegal_cnt), 32'(0));
    reset = 1'b0; step();
    check("post_rst_in_ready", 32'(in_ready), 32'(1));

    // Randomized stream, scored continuously by the model
    for (int i = 0; i < 3000; i++) begin
      int k;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (i % 200 < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 6) begin
        k = $urandom_range(0, 12);
        opcode = (tval[k] & tmask[k]) | (11'($urandom) & ~tmask[k]);
      end else begin
        opcode = 11'($urandom);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("final_empty", 32'(out_valid), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
# alu_op_decoder

Streaming decoder turning 11-bit LEGv8 opcodes into the 3-bit ALU select code (plus flag/immediate controls) consumed by the datapath's ALU result mux. Sits between instruction fetch and execute. Valid/ready on both sides, one-cycle registered latency, 2-entry skid buffer so `in_ready` never combinationally depends on `out_ready`. Keeps a saturating count of illegal opcodes for debug.

## Interface
Parameters:
- `CNT_W`, 8: width of the illegal-opcode counter.

Ports:
- `clk`  input  1  system clock, all state on rising edge.
- `reset`  input  1  synchronous, active-high.
- `in_valid`  input  1  opcode present.
- `in_ready`  output  1  decoder can accept.
- `opcode`  input  11  instruction[31:21].
- `out_valid`  output  1  decoded word available.
- `out_ready`  input  1  execute stage accepts.
- `alu_cntrl`  output  3  ALU select code.
- `set_flags`  output  1  update NZCV.
- `use_imm`  output  1  B operand is immediate.
- `illegal`  output  1  opcode not recognised.
- `illegal_cnt`  output  CNT_W  saturating illegal count.

## Operation
- ALU select codes (fixed by the ALU mux): 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor. 001 and 111 never driven.
- Decode (x = don't care), output {alu_cntrl, set_flags, use_imm}:
  - ADD 10001011000 -> 010,0,0; ADDS 10101011000 -> 010,1,0.
  - SUB 11001011000 -> 011,0,0; SUBS 11101011000 -> 011,1,0.
  - AND 10001010000 -> 100,0,0; ORR 10101010000 -> 101,0,0; EOR 11001010000 -> 110,0,0.
  - ADDI 1001000100x -> 010,0,1; SUBI 1101000100x -> 011,0,1.
  - LDUR 11111000010, STUR 11111000000 -> 010,0,1.
  - CBZ 10110100xxx -> 000,0,0.
  - B 000101xxxxx -> 000,0,0.
  - Anything else -> 000,0,0 with `illegal`=1. Illegal words are still passed downstream.
- Priority: exact 11-bit matches checked before wildcard patterns; the listed patterns do not overlap.
- Accept on `in_valid && in_ready`. Emit on `out_valid && out_ready`.
- Skid buffer: main output register plus one spill entry.
  - `in_ready` = spill entry empty, registered.
  - If the output is held (`out_valid && !out_ready`) while an input is accepted, the decoded word goes to spill.
  - When the output drains, spill moves to main.
- `illegal_cnt` increments by 1 when an illegal opcode is accepted (at acceptance, not emission). It saturates at all-ones with no wrap.
- Reset values:
  - `out_valid`=0, `in_ready`=1 (first cycle after reset deasserts).
  - `alu_cntrl`=000, `set_flags`=0, `use_imm`=0, `illegal`=0, `illegal_cnt`=0.
  - Spill entry empty.

## Timing
- Latency: opcode accepted in cycle N is on the outputs with `out_valid`=1 in cycle N+1, provided main was empty or draining in N.
- Throughput: 1 word/cycle while `out_ready`=1.
- Output payload is stable while `out_valid && !out_ready` (AXI-style hold). `out_valid` never drops without a handshake.
- Backpressure: first stalled cycle accepts one more word into spill; `in_ready` falls the following cycle. Once `out_ready` returns, `in_ready` rises the cycle after spill drains into main.
- Simultaneous accept and emit with spill empty: main reloads directly, no bubble.
- Simultaneous accept and emit with spill full: cannot occur, because `in_ready`=0.
- Reset mid-stream: all in-flight words discarded, counter cleared, no partial outputs the cycle after reset.
- Counter saturated at 2^CNT_W−1 plus another illegal accept: stays at 2^CNT_W−1.

## Structure
- Shared package `alu_pkg`:
  - `localparam` select codes `ALU_PASS_B`, `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_XOR`.
  - Packed struct `dec_word_t` {cntrl, set_flags, use_imm, illegal}.
  - Opcode constants.
- Decode is a pure `always_comb` function in the top.
- Sub-module `skid_buf`, parameterised on payload width, holds main + spill registers and the handshake.

## Test plan
- Stream ADD, SUBS, ORR, EOR, ADDI(10010001001) with `out_ready`=1 -> alu_cntrl 010,011,101,110,010 on consecutive cycles starting cycle after first accept. `set_flags` 1 only for SUBS, `use_imm` 1 only for ADDI.
- Hold `out_ready`=0 while presenting AND then ORR -> outputs hold 100. `in_ready` drops after the second accept. Releasing `out_ready` yields 100 then 101 with no loss or duplication.
- Opcode 00000000000 accepted 3 times -> `illegal`=1, alu_cntrl 000 each time, `illegal_cnt`=3.
- With CNT_W=2, accept 5 illegal opcodes -> `illegal_cnt` reaches 3 and stays at 3.
- Assert `reset` with spill full and `out_valid`=1 -> next cycle `out_valid`=0, `illegal_cnt`=0. The cycle after reset deasserts, `in_ready`=1.
- Random opcode/ready stream vs. reference model -> every accepted opcode emitted exactly once, in order, with correct decode, and no 001/111 codes.
